// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: Op encodings,
// FSM state encoding, byte-lane constants and small lane helper functions.
package dmem_pkg;

    typedef enum logic [2:0] {
        OpLw  = 3'b000,
        OpLh  = 3'b001,
        OpLb  = 3'b010,
        OpLhu = 3'b011,
        OpLbu = 3'b100,
        OpSw  = 3'b101,
        OpSh  = 3'b110,
        OpSb  = 3'b111
    } dmem_op_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRd    = 3'd1,
        StRmwRd = 3'd2,
        StWr    = 3'd3,
        StDone  = 3'd4
    } dmem_state_e;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_ALL  = 4'b1111;
    localparam logic [3:0] LANE_H0   = 4'b0011;
    localparam logic [3:0] LANE_H1   = 4'b1100;
    localparam logic [3:0] LANE_B0   = 4'b0001;

    function automatic logic is_load(dmem_op_e op);
        logic ld;
        case (op)
            OpSw, OpSh, OpSb: ld = 1'b0;
            default:          ld = 1'b1;
        endcase
        return ld;
    endfunction

    function automatic logic is_misaligned(dmem_op_e op, logic [1:0] off);
        logic mis;
        case (op)
            OpLw, OpSw:        mis = (off != 2'b00);
            OpLh, OpLhu, OpSh: mis = off[0];
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte lanes touched by a store; loads and sw cover the whole word.
    function automatic logic [3:0] lane_mask(dmem_op_e op, logic [1:0] off);
        logic [3:0] m;
        case (op)
            OpSh:    m = off[1] ? LANE_H1 : LANE_H0;
            OpSb:    m = LANE_B0 << off;
            default: m = LANE_ALL;
        endcase
        return m;
    endfunction

    // Store data copied into every lane it could occupy.
    function automatic logic [31:0] replicate(dmem_op_e op, logic [31:0] wdata);
        logic [31:0] r;
        case (op)
            OpSh:    r = {2{wdata[15:0]}};
            OpSb:    r = {4{wdata[7:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_extract.sv
// Combinational lane handling: load lane select with sign/zero extension and
// store merge of a half/byte into a previously read word.
module dmem_lane_extract
    import dmem_pkg::*;
(
    input  dmem_op_e    op,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [3:0]  lanes;
    logic [31:0] byte_mask;
    logic [31:0] wrep;

    // Select and extend the addressed lane; build the read-modify-write word.
    always_comb begin
        // Halves are aligned, so shifting by the byte offset also selects by off[1].
        shifted = rdata >> {off, 3'b000};
        case (op)
            OpLh:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            OpLhu:   load_data = {16'h0000, shifted[15:0]};
            OpLb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            OpLbu:   load_data = {24'h000000, shifted[7:0]};
            default: load_data = rdata;
        endcase

        lanes = lane_mask(op, off);
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{lanes[i]}};
        end
        wrep   = replicate(op, wdata);
        merged = (rdata & ~byte_mask) | (wrep & byte_mask);
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory access controller. Sequences loads, word stores and
// sub-word stores (read-modify-write) against a request/ack memory port,
// detects misalignment and ack timeouts, and freezes the pipeline meanwhile.
// Build option: DMEM_BYTE_ENABLE_EN makes sh/sb a single byte-enabled write.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic              Stall,
    output logic              Done,
    output logic [31:0]       LoadData,
    output logic              Fault,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic [3:0]        MemBe,
    input  logic              MemAck,
    input  logic [31:0]       MemRData
);

    localparam logic [7:0] CntLast = 8'(ACK_TIMEOUT - 1);

    dmem_state_e       state_q, state_d;
    dmem_op_e          op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [31:0]       load_data_q, load_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;

    dmem_op_e    req_op;
    logic        req_misaligned;
    logic        in_access;
    logic        timeout;
    logic [31:0] ext_load;
    logic [31:0] ext_merged;

    assign req_op         = dmem_op_e'(Op);
    assign req_misaligned = is_misaligned(req_op, Addr[1:0]);
    assign in_access      = (state_q == StRd) || (state_q == StRmwRd) || (state_q == StWr);
    assign timeout        = in_access && !MemAck && (cnt_q == CntLast);

    dmem_lane_extract u_lane (
        .op        (op_q),
        .off       (off_q),
        .rdata     (MemRData),
        .wdata     (wdata_q),
        .load_data (ext_load),
        .merged    (ext_merged)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: decode on accept, advance on ack or timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    if (req_misaligned) begin
                        state_d = StDone;
                    end else if (is_load(req_op)) begin
                        state_d = StRd;
                    end else if (req_op == OpSw) begin
                        state_d = StWr;
                    end else begin
`ifdef DMEM_BYTE_ENABLE_EN
                        state_d = StWr;
`else
                        state_d = StRmwRd;
`endif
                    end
                end
            end
            StRd: begin
                if (MemAck || timeout) state_d = StDone;
            end
            StRmwRd: begin
                if (MemAck) begin
                    state_d = StWr;
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StWr: begin
                if (MemAck || timeout) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; Stall is forced low while reset is held.
    always_comb begin
        MemReq = in_access;
        MemWe  = (state_q == StWr);
        Done   = (state_q == StDone);
        Fault  = (state_q == StDone) && fault_q;
        Stall  = Rst_n && Req && (state_q != StDone);
    end

    // Datapath next-state: latch the request, capture read data, count waits.
    always_comb begin
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        cnt_d       = '0;
        fault_d     = fault_q;
        load_data_d = load_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        if (in_access && !MemAck && !timeout) cnt_d = cnt_q + 8'd1;

        case (state_q)
            StIdle: begin
                if (Req) begin
                    op_d        = req_op;
                    off_d       = Addr[1:0];
                    wdata_d     = WriteData;
                    fault_d     = req_misaligned;
                    load_data_d = '0;
                    mem_addr_d  = {Addr[ADDR_W-1:2], 2'b00};
`ifdef DMEM_BYTE_ENABLE_EN
                    mem_wdata_d = replicate(req_op, WriteData);
                    mem_be_d    = lane_mask(req_op, Addr[1:0]);
`else
                    mem_wdata_d = WriteData;
                    mem_be_d    = LANE_ALL;
`endif
                end
            end
            StRd: begin
                if (MemAck) load_data_d = ext_load;
            end
            StRmwRd: begin
                if (MemAck) mem_wdata_d = ext_merged;
            end
            default: ;
        endcase

        if (timeout) begin
            fault_d     = 1'b1;
            load_data_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op_q        <= OpLw;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= LANE_NONE;
        end else begin
            op_q        <= op_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign LoadData = load_data_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemBe    = mem_be_q;

endmodule
